// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID/EX control decoder: opcode classes,
// FSM states, the control bundle and its bubble value.
package pipe_ctrl_pkg;

  localparam logic [1:0] CLS_LOAD  = 2'b00;
  localparam logic [1:0] CLS_STORE = 2'b01;
  localparam logic [1:0] CLS_ALU   = 2'b10;
  localparam logic [1:0] CLS_JUMP  = 2'b11;

  // Width of the wrong-path slot counter (supports 0..15 slots)
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic jump;
    logic reg_write;
    logic mem_write;
    logic mem_read;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Map an opcode class onto its ID/EX control bundle
  function automatic ctrl_t decode_cls(input logic [1:0] cls);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (cls)
      CLS_LOAD:  begin c.reg_write = 1'b1; c.mem_read = 1'b1; end
      CLS_STORE: c.mem_write = 1'b1;
      CLS_ALU:   c.reg_write = 1'b1;
      CLS_JUMP:  begin c.jump = 1'b1; c.reg_write = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard comparator: flags a decode instruction that reads the
// destination of a load currently sitting in ID/EX.
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 3
) (
  input  logic              valid,
  input  logic              run,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [1:0]        cls,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              stall
);

  // Jumps are never held; register 0 is compared like any other
  always_comb begin
    stall = valid && run && ex_valid && ex_mem_read && (cls != CLS_JUMP) &&
            ((ex_rd == rs) || (ex_rd == rt));
  end

endmodule

// File: rtl/pipe_ctrl_decoder.sv
// Registered ID/EX control decoder with load-use stall and jump flush.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 4,
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [REG_AW-1:0]   i_rs,
  input  logic [REG_AW-1:0]   i_rt,
  input  logic [REG_AW-1:0]   i_rd,
  output logic                o_stall,
  output logic                o_flush,
  output logic                o_ex_valid,
  output logic                o_jump,
  output logic                o_reg_write,
  output logic                o_mem_write,
  output logic                o_mem_read,
  output logic [OPCODE_W-3:0] o_alufunc,
  output logic [REG_AW-1:0]   o_rd
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_flush_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LD = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam bit                     FLUSH_EN = (FLUSH_CYCLES != 0);

  state_t                 state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  ctrl_t                  ex_ctrl;
  ctrl_t                  dec_ctrl;
  logic [1:0]             cls;
  logic [OPCODE_W-3:0]    alufunc;
  logic                   run;
  logic                   accept;

  // Split opcode into class and ALU function, and decode the class
  always_comb begin
    cls      = i_opcode[OPCODE_W-1:OPCODE_W-2];
    alufunc  = i_opcode[OPCODE_W-3:0];
    dec_ctrl = decode_cls(cls);
    run      = (state == ST_RUN);
    accept   = i_valid && !o_stall && run;
  end

  pipe_ctrl_hazard #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .valid       (i_valid),
    .run         (run),
    .ex_valid    (o_ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .cls         (cls),
    .ex_rd       (o_rd),
    .rs          (i_rs),
    .rt          (i_rt),
    .stall       (o_stall)
  );

  // RUN/FLUSH FSM plus the ID/EX register; anything not accepted becomes a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      flush_cnt  <= '0;
      o_flush    <= 1'b0;
      ex_ctrl    <= CTRL_BUBBLE;
      o_ex_valid <= 1'b0;
      o_alufunc  <= '0;
      o_rd       <= '0;
    end else begin
      ex_ctrl    <= CTRL_BUBBLE;
      o_ex_valid <= 1'b0;
      o_alufunc  <= '0;
      o_rd       <= '0;
      case (state)
        ST_RUN: begin
          if (accept) begin
            ex_ctrl    <= dec_ctrl;
            o_ex_valid <= 1'b1;
            o_alufunc  <= alufunc;
            o_rd       <= i_rd;
            if (FLUSH_EN && (cls == CLS_JUMP)) begin
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_LD;
              o_flush   <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Wrong-path slot squashed; a jump here never reloads the counter
          flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
          if (flush_cnt == FLUSH_CNT_W'(1)) begin
            state   <= ST_RUN;
            o_flush <= 1'b0;
          end
        end
        default: begin
          state   <= ST_RUN;
          o_flush <= 1'b0;
        end
      endcase
    end
  end

  assign o_jump      = ex_ctrl.jump;
  assign o_reg_write = ex_ctrl.reg_write;
  assign o_mem_write = ex_ctrl.mem_write;
  assign o_mem_read  = ex_ctrl.mem_read;

`ifdef PIPE_CTRL_PERF_CNT_EN
  // Saturating counts of stall cycles and flush cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (o_flush && (o_flush_cnt != '1)) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Directed bench for pipe_ctrl_decoder (FLUSH_CYCLES=2); the perf-counter
// section is built only when PIPE_CTRL_PERF_CNT_EN is defined.
module tb_pipe_ctrl_decoder;

  logic       clk;
  logic       reset;
  logic       i_valid;
  logic [3:0] i_opcode;
  logic [2:0] i_rs;
  logic [2:0] i_rt;
  logic [2:0] i_rd;
  logic       o_stall;
  logic       o_flush;
  logic       o_ex_valid;
  logic       o_jump;
  logic       o_reg_write;
  logic       o_mem_write;
  logic       o_mem_read;
  logic [1:0] o_alufunc;
  logic [2:0] o_rd;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [1:0] o_stall_cnt;
  logic [1:0] o_flush_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipe_ctrl_decoder #(
    .OPCODE_W     (4),
    .REG_AW       (3),
    .FLUSH_CYCLES (2)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .CNT_W        (2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_opcode    (i_opcode),
    .i_rs        (i_rs),
    .i_rt        (i_rt),
    .i_rd        (i_rd),
    .o_stall     (o_stall),
    .o_flush     (o_flush),
    .o_ex_valid  (o_ex_valid),
    .o_jump      (o_jump),
    .o_reg_write (o_reg_write),
    .o_mem_write (o_mem_write),
    .o_mem_read  (o_mem_read),
    .o_alufunc   (o_alufunc),
    .o_rd        (o_rd)
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the ID/EX bundle and flush flag
  task automatic chk_ex(input string tag, input logic v, input logic j, input logic rw,
                        input logic mw, input logic mr, input logic [1:0] alu,
                        input logic [2:0] rd, input logic fl);
    chk({tag, ".ex_valid"},  32'(o_ex_valid),  32'(v));
    chk({tag, ".jump"},      32'(o_jump),      32'(j));
    chk({tag, ".reg_write"}, 32'(o_reg_write), 32'(rw));
    chk({tag, ".mem_write"}, 32'(o_mem_write), 32'(mw));
    chk({tag, ".mem_read"},  32'(o_mem_read),  32'(mr));
    chk({tag, ".alufunc"},   32'(o_alufunc),   32'(alu));
    chk({tag, ".rd"},        32'(o_rd),        32'(rd));
    chk({tag, ".flush"},     32'(o_flush),     32'(fl));
  endtask

  // Present an instruction at the falling edge and check the combinational stall
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                      input logic exp_stall);
    @(negedge clk);
    i_valid  = v;
    i_opcode = op;
    i_rs     = rs;
    i_rt     = rt;
    i_rd     = rd;
    #1;
    chk({tag, ".stall"}, 32'(o_stall), 32'(exp_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_opcode = '0;
    i_rs     = '0;
    i_rt     = '0;
    i_rd     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    chk("reset.stall", 32'(o_stall), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    // ALU decode
    step("alu1", 1, 4'b1011, 3'd1, 3'd2, 3'd5, 0); tick();
    chk_ex("alu1", 1, 0, 1, 0, 0, 2'd3, 3'd5, 0);

    // Load followed by a dependent ALU: one stall, one bubble
    step("ld1", 1, 4'b0001, 3'd0, 3'd0, 3'd3, 0); tick();
    chk_ex("ld1", 1, 0, 1, 0, 1, 2'd1, 3'd3, 0);
    step("use1", 1, 4'b1000, 3'd3, 3'd0, 3'd6, 1); tick();
    chk_ex("use1.bub", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    step("use1.hold", 1, 4'b1000, 3'd3, 3'd0, 3'd6, 0); tick();
    chk_ex("use1.acc", 1, 0, 1, 0, 0, 2'd0, 3'd6, 0);

    // Load followed by an independent ALU: no stall
    step("ld2", 1, 4'b0010, 3'd0, 3'd0, 3'd3, 0); tick();
    chk_ex("ld2", 1, 0, 1, 0, 1, 2'd2, 3'd3, 0);
    step("nodep", 1, 4'b1001, 3'd4, 3'd2, 3'd7, 0); tick();
    chk_ex("nodep", 1, 0, 1, 0, 0, 2'd1, 3'd7, 0);

    // Register 0 matches on rt like any register; store controls
    step("ld3", 1, 4'b0000, 3'd1, 3'd1, 3'd0, 0); tick();
    chk_ex("ld3", 1, 0, 1, 0, 1, 2'd0, 3'd0, 0);
    step("st1", 1, 4'b0111, 3'd1, 3'd0, 3'd2, 1); tick();
    chk_ex("st1.bub", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    step("st1.hold", 1, 4'b0111, 3'd1, 3'd0, 3'd2, 0); tick();
    chk_ex("st1.acc", 1, 0, 0, 1, 0, 2'd3, 3'd2, 0);

    // Jump behind a load to its source register is not stalled; two-slot flush
    step("ld4", 1, 4'b0000, 3'd0, 3'd0, 3'd2, 0); tick();
    chk_ex("ld4", 1, 0, 1, 0, 1, 2'd0, 3'd2, 0);
    step("jmp1", 1, 4'b1101, 3'd2, 3'd0, 3'd1, 0); tick();
    chk_ex("jmp1", 1, 1, 1, 0, 0, 2'd1, 3'd1, 1);
    step("wp1", 1, 4'b1001, 3'd0, 3'd0, 3'd4, 0); tick();
    chk_ex("wp1", 0, 0, 0, 0, 0, 2'd0, 3'd0, 1);
    step("wp2", 1, 4'b1010, 3'd0, 3'd0, 3'd5, 0); tick();
    chk_ex("wp2", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    step("after1", 1, 4'b1011, 3'd0, 3'd0, 3'd6, 0); tick();
    chk_ex("after1", 1, 0, 1, 0, 0, 2'd3, 3'd6, 0);

    // Wrong-path jump during flush is squashed and does not reload the counter
    step("jmp2", 1, 4'b1100, 3'd0, 3'd0, 3'd1, 0); tick();
    chk_ex("jmp2", 1, 1, 1, 0, 0, 2'd0, 3'd1, 1);
    step("wpj", 1, 4'b1110, 3'd1, 3'd1, 3'd2, 0); tick();
    chk_ex("wpj", 0, 0, 0, 0, 0, 2'd0, 3'd0, 1);
    step("wpu", 1, 4'b1000, 3'd0, 3'd0, 3'd3, 0); tick();
    chk_ex("wpu", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    step("after2", 1, 4'b1000, 3'd1, 3'd1, 3'd4, 0); tick();
    chk_ex("after2", 1, 0, 1, 0, 0, 2'd0, 3'd4, 0);

    // Reset asserted mid-flush clears everything immediately
    step("jmp3", 1, 4'b1111, 3'd0, 3'd0, 3'd7, 0); tick();
    chk_ex("jmp3", 1, 1, 1, 0, 0, 2'd3, 3'd7, 1);
    @(negedge clk);
    i_opcode = 4'b1000;
    reset    = 1'b1;
    #1;
    chk_ex("rst_mid", 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
    chk("rst_mid.stall", 32'(o_stall), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1, 4'b1011, 3'd1, 3'd2, 3'd5, 0); tick();
    chk_ex("post_rst", 1, 0, 1, 0, 0, 2'd3, 3'd5, 0);

`ifdef PIPE_CTRL_PERF_CNT_EN
    // Five load-use stalls saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      step("pc.ld", 1, 4'b0000, 3'd0, 3'd0, 3'd1, 0); tick();
      step("pc.use", 1, 4'b1000, 3'd1, 3'd0, 3'd2, 1); tick();
      step("pc.hold", 1, 4'b1000, 3'd1, 3'd0, 3'd2, 0); tick();
      chk($sformatf("stall_cnt[%0d]", i), 32'(o_stall_cnt), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    chk("flush_cnt", 32'(o_flush_cnt), 32'd0);
`endif

    @(negedge clk);
    i_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
